// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline control unit for the 5-stage CPU. It looks at the instruction in
// ID, the instruction in EX and the data-cache busy flag, and decides each
// cycle whether the front of the pipeline advances, stalls with a bubble,
// flushes IF/ID, or freezes completely while memory catches up.
//
// A load feeding a branch comparator in ID needs two stall cycles. The first
// comes from the live load-use match. The HOLD1 state supplies the second,
// because by then the load has moved on to MEM and no longer matches.
//
// Three saturating counters record stall, freeze and flush cycles for
// performance reporting.
//
// Ports
//   clk_i            clock, all state updates on posedge
//   rst_i            synchronous active-high reset
//   IFID_Rs_i        rs field of the ID instruction
//   IFID_Rt_i        rt field of the ID instruction
//   IFID_UsesRt_i    ID instruction reads rt
//   IsBranch_i       ID instruction is a conditional branch
//   BranchTaken_i    branch in ID resolved taken this cycle
//   Jump_i           ID instruction is j/jal
//   IDEX_MemRead_i   EX instruction is a load
//   IDEX_RegWrite_i  EX instruction writes a register
//   IDEX_WriteReg_i  destination register of the EX instruction
//   DcacheStall_i    MEM-stage access not complete
//   PCWrite_o        PC update enable
//   IFID_Stall_o     hold IF/ID
//   IFID_Flush_o     clear IF/ID
//   IDEX_Bubble_o    zero ID/EX control fields
//   Freeze_o         hold ID/EX, EX/MEM, MEM/WB
//   StallCnt_o       hazard-stall cycle count (saturating)
//   FreezeCnt_o      freeze cycle count (saturating)
//   FlushCnt_o       flush cycle count (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IFID_Rs_i,
   input  logic [4:0]       IFID_Rt_i,
   input  logic             IFID_UsesRt_i,
   input  logic             IsBranch_i,
   input  logic             BranchTaken_i,
   input  logic             Jump_i,
   input  logic             IDEX_MemRead_i,
   input  logic             IDEX_RegWrite_i,
   input  logic [4:0]       IDEX_WriteReg_i,
   input  logic             DcacheStall_i,
   output logic             PCWrite_o,
   output logic             IFID_Stall_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Bubble_o,
   output logic             Freeze_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic [CNT_W-1:0] FreezeCnt_o,
   output logic [CNT_W-1:0] FlushCnt_o
);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      HOLD1 = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic dst_valid;
   logic match;
   logic load_use;
   logic br_alu;
   logic br_load;
   logic hazard;
   logic freeze;
   logic flush_req;

   // One-cycle event strobes for the counters.
   logic stall_evt;
   logic freeze_evt;
   logic flush_evt;

   // --------------------------------------------------------------------------
   // Hazard detection
   // --------------------------------------------------------------------------
   // $0 is hard-wired to zero, so an EX instruction targeting it can never
   // produce a value that ID depends on.
   assign dst_valid = (IDEX_WriteReg_i != 5'd0);

   assign match = dst_valid &&
                  ((IDEX_WriteReg_i == IFID_Rs_i) ||
                   (IFID_UsesRt_i && (IDEX_WriteReg_i == IFID_Rt_i)));

   assign load_use = IDEX_MemRead_i && match;

   // An ALU result feeding a branch comparator is forwarded from EX/MEM on
   // the next cycle, so a single stall is enough.
   assign br_alu  = IsBranch_i && IDEX_RegWrite_i && !IDEX_MemRead_i && match;
   assign br_load = IsBranch_i && load_use;

   assign hazard    = (state_q == HOLD1) || load_use || br_alu;
   assign freeze    = DcacheStall_i;
   assign flush_req = BranchTaken_i || Jump_i;

   // --------------------------------------------------------------------------
   // Next state and control outputs
   // --------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the if/case chain leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      PCWrite_o     = 1'b1;
      IFID_Stall_o  = 1'b0;
      IFID_Flush_o  = 1'b0;
      IDEX_Bubble_o = 1'b0;
      Freeze_o      = 1'b0;
      stall_evt     = 1'b0;
      freeze_evt    = 1'b0;
      flush_evt     = 1'b0;

      if (rst_i) begin
         // Outputs stay at their defaults; any pending HOLD1 is dropped.
         state_d = RUN;
      end else if (freeze) begin
         // Whole pipeline waits on the data cache. State holds, so a pending
         // HOLD1 stall is taken after release.
         Freeze_o     = 1'b1;
         PCWrite_o    = 1'b0;
         IFID_Stall_o = 1'b1;
         freeze_evt   = 1'b1;
      end else begin
         if (hazard) begin
            // A taken branch here is ignored: it stays in ID and is
            // re-evaluated once its operands are ready.
            PCWrite_o     = 1'b0;
            IFID_Stall_o  = 1'b1;
            IDEX_Bubble_o = 1'b1;
            stall_evt     = 1'b1;
         end else if (flush_req) begin
            IFID_Flush_o = 1'b1;
            flush_evt    = 1'b1;
         end

         unique case (state_q)
            RUN:     if (br_load) state_d = HOLD1;
            HOLD1:   state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Performance counters
   // --------------------------------------------------------------------------
   // Saturate at all-ones so a long run reads as "at least this many" rather
   // than wrapping to a misleadingly small value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         StallCnt_o  <= '0;
         FreezeCnt_o <= '0;
         FlushCnt_o  <= '0;
      end else begin
         if (stall_evt) begin
            StallCnt_o <= sat_inc(StallCnt_o);
         end
         if (freeze_evt) begin
            FreezeCnt_o <= sat_inc(FreezeCnt_o);
         end
         if (flush_evt) begin
            FlushCnt_o <= sat_inc(FlushCnt_o);
         end
      end
   end

endmodule
